// File: rtl/rst_seq_pkg.sv
// Shared types and widths for the PLL reset sequencer: state encoding, counter widths and a
// saturating-increment helper for the status counters.
package rst_seq_pkg;

    localparam int CNT_W  = 20;
    localparam int STAT_W = 8;
    localparam int STG_W  = 3;

    typedef logic [2:0] state_t;

    localparam state_t PLL_RST   = 3'd0;
    localparam state_t WAIT_LOCK = 3'd1;
    localparam state_t STABLE    = 3'd2;
    localparam state_t RELEASE   = 3'd3;
    localparam state_t RUN       = 3'd4;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + {{(STAT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pll_reset_seq_if.sv
// PLL-facing and reset-fanout signals of the sequencer, plus the FSM state for observation.
// All signals are levels (no valid/ready handshake): pll_locked is sampled every refclk edge
// through a synchronizer, every output is a registered level that holds until the FSM changes it.
interface pll_reset_seq_if #(
    parameter int N_STAGES = 2
);
    import rst_seq_pkg::*;

    logic                pll_locked;
    logic                pll_rst;
    logic [N_STAGES-1:0] rst_out;
    logic                ready;
    logic [STAT_W-1:0]   lock_loss_cnt;
    logic [STAT_W-1:0]   retry_cnt;
    state_t              dbg_state;

    modport master (
        input  pll_locked,
        output pll_rst, rst_out, ready, lock_loss_cnt, retry_cnt, dbg_state
    );

    modport slave (
        output pll_locked,
        input  pll_rst, rst_out, ready, lock_loss_cnt, retry_cnt, dbg_state
    );

endinterface

// File: rtl/bit_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module bit_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_reset_seq.sv
// PLL reset sequencer: pulses pll_rst, waits for a stable lock, then releases staged resets.
// Status counters (lock_loss_cnt, retry_cnt) are built only when RST_SEQ_STATUS_EN is defined.
module pll_reset_seq
    import rst_seq_pkg::*;
#(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STABLE_CYC   = 1024,
    parameter int N_STAGES     = 2,
    parameter int STAGE_GAP    = 16
) (
    input  logic             refclk,
    input  logic             rst,
    pll_reset_seq_if.master  bus
);

    localparam logic [CNT_W-1:0] PLL_RST_LD = CNT_W'(PLL_RST_CYC - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LD  = CNT_W'(STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [STG_W-1:0] STAGE_LAST = STG_W'(N_STAGES - 1);
    localparam logic [STG_W-1:0] STAGE_ONE  = STG_W'(1);

    logic                lk;
    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [STG_W-1:0]    stage;
    logic                pll_rst_q;
    logic [N_STAGES-1:0] rst_out_q;
    logic                ready_q;
`ifdef RST_SEQ_STATUS_EN
    logic [STAT_W-1:0]   loss_q;
    logic [STAT_W-1:0]   retry_q;
`endif

    bit_sync_2ff u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (bus.pll_locked),
        .q   (lk)
    );

    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= PLL_RST;
            cnt       <= PLL_RST_LD;
            stage     <= '0;
            pll_rst_q <= 1'b1;
            rst_out_q <= '1;
            ready_q   <= 1'b0;
`ifdef RST_SEQ_STATUS_EN
            loss_q    <= '0;
            retry_q   <= '0;
`endif
        end else begin
            case (state)
                PLL_RST: begin
                    if (cnt == '0) begin
                        state     <= WAIT_LOCK;
                        cnt       <= TIMEOUT_LD;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                // A lock seen in the timeout cycle wins over the retry.
                WAIT_LOCK: begin
                    if (lk) begin
                        state <= STABLE;
                        cnt   <= STABLE_LD;
                    end else if (cnt == '0) begin
                        state     <= PLL_RST;
                        cnt       <= PLL_RST_LD;
                        pll_rst_q <= 1'b1;
`ifdef RST_SEQ_STATUS_EN
                        retry_q   <= sat_inc(retry_q);
`endif
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                STABLE: begin
                    if (!lk) begin
                        state <= WAIT_LOCK;
                        cnt   <= TIMEOUT_LD;
                    end else if (cnt == '0) begin
                        state <= RELEASE;
                        cnt   <= GAP_LD;
                        stage <= '0;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                // Shifting left drops bit 0 first; already released stages stay low.
                RELEASE: begin
                    if (!lk) begin
                        state     <= PLL_RST;
                        cnt       <= PLL_RST_LD;
                        pll_rst_q <= 1'b1;
                        rst_out_q <= '1;
                        ready_q   <= 1'b0;
                    end else if (cnt == '0) begin
                        rst_out_q <= rst_out_q << 1;
                        if (stage == STAGE_LAST) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            stage <= stage + STAGE_ONE;
                            cnt   <= GAP_LD;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state     <= PLL_RST;
                        cnt       <= PLL_RST_LD;
                        pll_rst_q <= 1'b1;
                        rst_out_q <= '1;
                        ready_q   <= 1'b0;
`ifdef RST_SEQ_STATUS_EN
                        loss_q    <= sat_inc(loss_q);
`endif
                    end
                end
                default: begin
                    state     <= PLL_RST;
                    cnt       <= PLL_RST_LD;
                    pll_rst_q <= 1'b1;
                    rst_out_q <= '1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.rst_out   = rst_out_q;
    assign bus.ready     = ready_q;
    assign bus.dbg_state = state;
`ifdef RST_SEQ_STATUS_EN
    assign bus.lock_loss_cnt = loss_q;
    assign bus.retry_cnt     = retry_q;
`else
    assign bus.lock_loss_cnt = '0;
    assign bus.retry_cnt     = '0;
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq: directed scenarios plus random lock outages, every cycle checked
// against a phase/elapsed-time reference model through an expected-value queue.
module tb_pll_reset_seq;
    import rst_seq_pkg::*;

    localparam int PRC = 4;
    localparam int TO  = 50;
    localparam int SC  = 8;
    localparam int NS  = 2;
    localparam int GAP = 3;
    localparam int EW  = 2 + NS + 2 * STAT_W;

    localparam int M_ARM  = 0;
    localparam int M_WAIT = 1;
    localparam int M_STAB = 2;
    localparam int M_REL  = 3;
    localparam int M_RUN  = 4;

`ifdef RST_SEQ_STATUS_EN
    localparam bit STAT_ON = 1'b1;
`else
    localparam bit STAT_ON = 1'b0;
`endif

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    pll_reset_seq_if #(.N_STAGES(NS)) bus ();

    pll_reset_seq #(
        .PLL_RST_CYC  (PRC),
        .LOCK_TIMEOUT (TO),
        .STABLE_CYC   (SC),
        .N_STAGES     (NS),
        .STAGE_GAP    (GAP)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
        .bus    (bus)
    );

    always #10 refclk = ~refclk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [EW-1:0] exp_q[$];

    int ph = M_ARM;
    int t = 0;
    int loss = 0;
    int retry = 0;
    bit h1 = 1'b0;
    bit h2 = 1'b0;

    // Reference model: phase plus elapsed cycles in that phase; lock seen two edges late.
    task automatic model_step();
        bit lk;
        lk = h2;
        if (rst) begin
            ph = M_ARM; t = 0; loss = 0; retry = 0; h1 = 1'b0; h2 = 1'b0;
            return;
        end
        h2 = h1;
        h1 = bus.pll_locked;
        case (ph)
            M_ARM: begin
                t++;
                if (t == PRC) begin ph = M_WAIT; t = 0; end
            end
            M_WAIT: begin
                if (lk) begin
                    ph = M_STAB; t = 0;
                end else begin
                    t++;
                    if (t == TO) begin
                        ph = M_ARM; t = 0;
                        if (retry < 255) retry++;
                    end
                end
            end
            M_STAB: begin
                if (!lk) begin
                    ph = M_WAIT; t = 0;
                end else begin
                    t++;
                    if (t == SC) begin ph = M_REL; t = 0; end
                end
            end
            M_REL: begin
                if (!lk) begin
                    ph = M_ARM; t = 0;
                end else begin
                    t++;
                    if (t == GAP * NS) ph = M_RUN;
                end
            end
            default: begin
                if (!lk) begin
                    ph = M_ARM; t = 0;
                    if (loss < 255) loss++;
                end
            end
        endcase
    endtask

    function automatic logic [EW-1:0] model_out();
        logic [NS-1:0] ro;
        logic [STAT_W-1:0] l8, r8;
        for (int k = 0; k < NS; k++)
            ro[k] = !(ph == M_RUN || (ph == M_REL && t >= GAP * (k + 1)));
        l8 = STAT_ON ? STAT_W'(loss) : '0;
        r8 = STAT_ON ? STAT_W'(retry) : '0;
        return {ph == M_ARM, ph == M_RUN, ro, l8, r8};
    endfunction

    initial begin
        forever begin
            @(posedge refclk);
            model_step();
            exp_q.push_back(model_out());
        end
    end

    initial begin
        logic [EW-1:0] exp_v, act_v;
        forever begin
            @(posedge refclk);
            #1;
            if (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                act_v = {bus.pll_rst, bus.ready, bus.rst_out, bus.lock_loss_cnt, bus.retry_cnt};
                n_checks++;
                if (act_v !== exp_v) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: actual pll_rst=%b ready=%b rst_out=%b loss=%0d retry=%0d, required pll_rst=%b ready=%b rst_out=%b loss=%0d retry=%0d",
                             $time, act_v[EW-1], act_v[EW-2], act_v[2*STAT_W +: NS],
                             act_v[STAT_W +: STAT_W], act_v[0 +: STAT_W],
                             exp_v[EW-1], exp_v[EW-2], exp_v[2*STAT_W +: NS],
                             exp_v[STAT_W +: STAT_W], exp_v[0 +: STAT_W]);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge refclk);
    endtask

    task automatic check_val(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", name, act, req);
        end
    endtask

    task automatic wait_ready(input string name, input int budget);
        int c;
        c = 0;
        while (bus.ready !== 1'b1 && c < budget) begin
            @(negedge refclk);
            c++;
        end
        check_val({"ready_reached_", name}, int'(bus.ready === 1'b1), 1);
    endtask

    initial begin
        int c;
        logic [NS-1:0] ro_tmp;
        bus.pll_locked = 1'b1;

        // 1: reset with lock already present
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        wait_ready("power_up", 200);
        cyc(5);

        // 2: long outage with timeouts
        bus.pll_locked = 1'b0;
        cyc(120);
        check_val("retry_after_outage", int'(bus.retry_cnt), STAT_ON ? 2 : 0);
        ro_tmp = bus.rst_out;
        check_val("rst_out_held_in_outage", int'(ro_tmp), (1 << NS) - 1);
        bus.pll_locked = 1'b1;

        // 3: one-cycle glitch in the stable window
        c = 0;
        while (!(ph == M_STAB && t == 5) && c < 300) begin cyc(1); c++; end
        check_val("reached_stable_5", int'(ph == M_STAB && t == 5), 1);
        bus.pll_locked = 1'b0;
        cyc(1);
        bus.pll_locked = 1'b1;
        wait_ready("after_glitch", 200);
        cyc(4);

        // 4: lock loss in RUN
        bus.pll_locked = 1'b0;
        cyc(1);
        bus.pll_locked = 1'b1;
        cyc(2);
        ro_tmp = bus.rst_out;
        check_val("run_loss_rst_out", int'(ro_tmp), (1 << NS) - 1);
        check_val("run_loss_ready", int'(bus.ready), 0);
        check_val("run_loss_pll_rst", int'(bus.pll_rst), 1);
        check_val("run_loss_count", int'(bus.lock_loss_cnt), STAT_ON ? 2 : 0);

        // 5: rst while stage 0 released and stage 1 still held
        c = 0;
        while (bus.rst_out !== 2'b10 && c < 300) begin cyc(1); c++; end
        check_val("reached_partial_release", int'(bus.rst_out === 2'b10), 1);
        rst = 1'b1;
        cyc(1);
        ro_tmp = bus.rst_out;
        check_val("mid_release_rst_out", int'(ro_tmp), 3);
        check_val("mid_release_pll_rst", int'(bus.pll_rst), 1);
        check_val("mid_release_loss", int'(bus.lock_loss_cnt), 0);
        check_val("mid_release_retry", int'(bus.retry_cnt), 0);
        rst = 1'b0;
        wait_ready("after_rst", 200);

        // random outages of varying length, occasional reset
        for (int i = 0; i < 12; i++) begin
            bus.pll_locked = 1'b1;
            cyc($urandom_range(1, 40));
            bus.pll_locked = 1'b0;
            cyc($urandom_range(1, 70));
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                cyc($urandom_range(1, 3));
                rst = 1'b0;
            end
        end
        bus.pll_locked = 1'b1;
        wait_ready("random_end", 300);
        cyc(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
